dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: turns CPU load/store requests into single-cycle SRAM
// accesses with lane steering, sign/zero extension and illegal-request trapping.
module dmem_responder #(
    parameter int unsigned AW_WORDS  = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [31:0]         MEM_addr,
    input  logic [31:0]         MEM_WR_out,
    input  logic [2:0]          MEM_type,
    input  logic                MEM_rd_en,
    input  logic                MEM_wr_en,
    output logic [31:0]         MEM_data,
    output logic                MEM_ready,
    output logic                MEM_err,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [3:0]          sram_be,
    output logic [AW_WORDS-1:0] sram_addr,
    output logic [31:0]         sram_wdata,
    input  logic [31:0]         sram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdResp,
        StWrAck,
        StErrAck
    } state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  type_q, type_d;

    logic [31:0] offset;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic        in_range;
    logic        type_ok;
    logic        aligned;
    logic        dir_ok;
    logic        legal;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    // Request decode: every rule that turns a request into an error pulse.
    always_comb begin
        offset   = MEM_addr - BASE_ADDR;
        size     = MEM_type[1:0];
        lane     = MEM_addr[1:0];
        in_range = (MEM_addr >= BASE_ADDR) && ((offset >> (AW_WORDS + 2)) == 32'd0);
        type_ok  = (size != 2'b11) && (MEM_type != 3'b110);
        case (size)
            SzHalf:  aligned = ~lane[0];
            SzWord:  aligned = (lane == 2'b00);
            default: aligned = 1'b1;
        endcase
        dir_ok = !(MEM_rd_en && MEM_wr_en) && !(MEM_wr_en && MEM_type[2]);
        legal  = in_range && type_ok && aligned && dir_ok;
    end

    // Store data is replicated across all lanes; byte enables pick the live ones.
    always_comb begin
        case (size)
            SzByte: begin
                st_be    = 4'b0001 << lane;
                st_wdata = {4{MEM_WR_out[7:0]}};
            end
            SzHalf: begin
                st_be    = 4'b0011 << lane;
                st_wdata = {2{MEM_WR_out[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = MEM_WR_out;
            end
        endcase
    end

    // Load lane select and extension, using the lane/type captured at issue.
    always_comb begin
        rd_half = 16'(sram_rdata >> {lane_q, 3'b000});
        case (type_q)
            3'b000:  load_val = {{24{rd_half[7]}}, rd_half[7:0]};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_half[7:0]};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = sram_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        lane_d     = lane_q;
        type_d     = type_q;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        MEM_ready  = 1'b0;
        MEM_err    = 1'b0;
        case (state_q)
            StIdle: begin
                // Strobes are combinational, so hold them off while reset is asserted.
                if (Reset_n && (MEM_rd_en || MEM_wr_en)) begin
                    if (!legal) begin
                        state_d = StErrAck;
                    end else begin
                        sram_cs   = 1'b1;
                        sram_addr = offset[AW_WORDS+1:2];
                        if (MEM_rd_en) begin
                            lane_d  = lane;
                            type_d  = MEM_type;
                            state_d = StRdWait;
                        end else begin
                            sram_we    = 1'b1;
                            sram_be    = st_be;
                            sram_wdata = st_wdata;
                            state_d    = StWrAck;
                        end
                    end
                end
            end
            StRdWait: begin
                data_d  = load_val;
                state_d = StRdResp;
            end
            StRdResp: begin
                MEM_ready = 1'b1;
                state_d   = StIdle;
            end
            StWrAck: begin
                MEM_ready = 1'b1;
                state_d   = StIdle;
            end
            StErrAck: begin
                MEM_ready = 1'b1;
                MEM_err   = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            lane_q  <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
            type_q  <= type_d;
        end
    end

    assign MEM_data = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference memory, SRAM model, directed
// scenarios followed by randomized loads/stores.
module tb_dmem_responder;

    localparam int unsigned AW        = 10;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 4 << AW;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b1;
    logic [31:0]   MEM_addr = '0;
    logic [31:0]   MEM_WR_out = '0;
    logic [2:0]    MEM_type = '0;
    logic          MEM_rd_en = 1'b0;
    logic          MEM_wr_en = 1'b0;
    logic [31:0]   MEM_data;
    logic          MEM_ready;
    logic          MEM_err;
    logic          sram_cs;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int vectors = 0;
    int miscompares = 0;

    dmem_responder #(
        .AW_WORDS  (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .MEM_addr   (MEM_addr),
        .MEM_WR_out (MEM_WR_out),
        .MEM_type   (MEM_type),
        .MEM_rd_en  (MEM_rd_en),
        .MEM_wr_en  (MEM_wr_en),
        .MEM_data   (MEM_data),
        .MEM_ready  (MEM_ready),
        .MEM_err    (MEM_err),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 CLK = ~CLK;

    // SRAM model plus a monitor of the last access it saw.
    logic [31:0]   sram_mem [0:(1<<AW)-1];
    int            cs_count = 0;
    logic [AW-1:0] mon_addr;
    logic          mon_we;
    logic [3:0]    mon_be;
    logic [31:0]   mon_wdata;

    always @(posedge CLK) begin
        if (sram_cs) begin
            cs_count  <= cs_count + 1;
            mon_addr  <= sram_addr;
            mon_we    <= sram_we;
            mon_be    <= sram_be;
            mon_wdata <= sram_wdata;
            if (sram_we) begin
                for (int k = 0; k < 4; k++)
                    if (sram_be[k]) sram_mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: plain byte-addressed memory and the last load result.
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [31:0] last_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input bit rd, input bit wr, input logic [31:0] a,
                                      input logic [2:0] t);
        int unsigned sz;
        if (rd && wr) return 1'b1;
        if (t == 3'd3 || t == 3'd6 || t == 3'd7) return 1'b1;
        if (wr && t >= 3'd4) return 1'b1;
        sz = 1 << t[1:0];
        if (a % sz != 0) return 1'b1;
        if (a < BASE || (a - BASE) >= MEM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        int unsigned sz;
        int unsigned off;
        logic [31:0] raw;
        sz  = 1 << t[1:0];
        off = a - BASE;
        raw = '0;
        for (int i = 0; i < int'(sz); i++) raw = raw | (32'(ref_mem[off + i]) << (8 * i));
        if (t[2] == 1'b0 && sz < 4 && raw[8*sz-1]) raw = raw | ~((32'd1 << (8 * sz)) - 1);
        return raw;
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] wd, input string tag);
        bit          ill;
        bit          got;
        int          lat;
        int          cs0;
        int unsigned sz;
        int unsigned off;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] obs_data;
        logic        obs_err;

        ill      = is_illegal(rd, wr, a, t);
        exp_data = last_data;
        if (!ill && rd) exp_data = ref_load(a, t);
        cs0 = cs_count;

        @(posedge CLK);
        #1;
        MEM_rd_en  = rd;
        MEM_wr_en  = wr;
        MEM_addr   = a;
        MEM_type   = t;
        MEM_WR_out = wd;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 8) begin
            @(negedge CLK);
            if (MEM_ready) got = 1'b1;
            else begin
                @(posedge CLK);
                lat++;
            end
        end
        obs_data  = MEM_data;
        obs_err   = MEM_err;
        MEM_rd_en = 1'b0;
        MEM_wr_en = 1'b0;

        check({tag, " ready"}, 32'(got), 32'd1);
        check({tag, " latency"}, lat, (!ill && rd) ? 32'd3 : 32'd2);
        check({tag, " err"}, 32'(obs_err), 32'(ill));
        check({tag, " data"}, obs_data, exp_data);
        check({tag, " sram_cs count"}, cs_count - cs0, ill ? 32'd0 : 32'd1);

        if (!ill) begin
            off = a - BASE;
            check({tag, " sram_addr"}, 32'(mon_addr), off >> 2);
            check({tag, " sram_we"}, 32'(mon_we), 32'(wr));
            if (wr) begin
                sz     = 1 << t[1:0];
                exp_be = 4'(((1 << sz) - 1) << a[1:0]);
                for (int k = 0; k < 4; k++) exp_wdata[8*k +: 8] = wd[8*(k % sz) +: 8];
                check({tag, " sram_be"}, 32'(mon_be), 32'(exp_be));
                check({tag, " sram_wdata"}, mon_wdata, exp_wdata);
                for (int i = 0; i < int'(sz); i++) ref_mem[off + i] = wd[8*i +: 8];
            end else begin
                last_data = exp_data;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " MEM_data"}, MEM_data, 32'd0);
        check({tag, " MEM_ready"}, 32'(MEM_ready), 32'd0);
        check({tag, " MEM_err"}, 32'(MEM_err), 32'd0);
        check({tag, " sram_cs"}, 32'(sram_cs), 32'd0);
        check({tag, " sram_we"}, 32'(sram_we), 32'd0);
        check({tag, " sram_be"}, 32'(sram_be), 32'd0);
        check({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, " sram_wdata"}, sram_wdata, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spurious;
        int r;
        int k;
        logic [31:0] a;

        // Reset with an active request on the inputs: strobes must stay quiet.
        #1 Reset_n = 1'b0;
        MEM_rd_en  = 1'b1;
        MEM_addr   = 32'h44;
        MEM_type   = 3'b010;
        MEM_WR_out = 32'h1234_5678;
        #12;
        check_reset_outputs("reset");
        MEM_rd_en = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;

        // Preload a low window and the top four words through the DUT.
        for (int w = 0; w < 16; w++) txn(0, 1, 32'(4 * w), 3'b010, $urandom, "preload");
        for (int w = 1020; w < 1024; w++) txn(0, 1, 32'(4 * w), 3'b010, $urandom, "preload hi");

        txn(0, 1, 32'h10, 3'b010, 32'hDEAD_BEEF, "SW 0x10");
        txn(1, 0, 32'h10, 3'b010, 32'h0, "LW 0x10");
        check("LW 0x10 value", last_data, 32'hDEAD_BEEF);
        txn(0, 1, 32'h13, 3'b000, 32'h0000_0080, "SB 0x13");
        txn(1, 0, 32'h13, 3'b000, 32'h0, "LB 0x13");
        check("LB 0x13 value", last_data, 32'hFFFF_FF80);
        txn(1, 0, 32'h13, 3'b100, 32'h0, "LBU 0x13");
        check("LBU 0x13 value", last_data, 32'h0000_0080);
        txn(0, 1, 32'h22, 3'b001, 32'h0000_8001, "SH 0x22");
        txn(1, 0, 32'h22, 3'b001, 32'h0, "LH 0x22");
        check("LH 0x22 value", last_data, 32'hFFFF_8001);
        txn(1, 0, 32'h22, 3'b101, 32'h0, "LHU 0x22");
        check("LHU 0x22 value", last_data, 32'h0000_8001);
        txn(1, 0, 32'h20, 3'b101, 32'h0, "LHU 0x20");
        txn(1, 0, 32'h11, 3'b010, 32'h0, "LW 0x11 misaligned");
        txn(0, 1, 32'h23, 3'b001, 32'hFFFF, "SH 0x23 misaligned");
        txn(1, 1, 32'h0, 3'b010, 32'h0, "both enables");
        txn(1, 0, 32'h1000, 3'b010, 32'h0, "LW out of range");
        txn(1, 0, 32'h0, 3'b011, 32'h0, "load type 011");
        txn(0, 1, 32'h4, 3'b100, 32'h55, "store type 100");
        txn(1, 0, 32'hFFC, 3'b010, 32'h0, "LW top word");

        // Reset during RD_WAIT: outputs clear at once, the read is abandoned.
        @(posedge CLK);
        #1;
        MEM_rd_en = 1'b1;
        MEM_addr  = 32'h10;
        MEM_type  = 3'b010;
        @(posedge CLK);
        #1 Reset_n = 1'b0;
        #1;
        check_reset_outputs("reset in RD_WAIT");
        last_data = '0;
        MEM_rd_en = 1'b0;
        @(negedge CLK);
        Reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (MEM_ready) spurious++;
        end
        check("no ready after reset", spurious, 0);
        txn(1, 0, 32'h10, 3'b010, 32'h0, "LW after reset");

        // Randomized mix over the preloaded windows and just past the end.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 63));
            else if (r < 8) a = 32'hFF0 + 32'($urandom_range(0, 15));
            else if (r < 9) a = 32'h1000 + 32'($urandom_range(0, 15));
            else            a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            k = $urandom_range(0, 9);
            if (k < 5)      txn(1, 0, a, 3'($urandom_range(0, 7)), 32'h0, "rand load");
            else if (k < 9) txn(0, 1, a, 3'($urandom_range(0, 7)), $urandom, "rand store");
            else            txn(1, 1, a, 3'($urandom_range(0, 7)), $urandom, "rand both");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
